mesh_feeder: RTL

Control and data-injection stage that sits directly upstream of the 2D-mesh matrix multiplier. It holds two N×N matrices of 4-bit operands, A and B, loaded through a simple write port. On START it clears the mesh accumulators, then streams the operands into the mesh's west edge (rows of A) and north edge (columns of B) with the diagonal skew a systolic mesh requires. It drives the mesh-wide register enable and signals completion.

---
 rtl/mesh_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mesh_feeder.sv
// mesh_feeder: operand storage and skewed injection for an N x N systolic mesh.
// Holds matrices A and B, clears the mesh on START, then streams rows of A
// west-to-east and columns of B north-to-south with the diagonal skew the mesh
// needs, followed by zero-injection drain steps and a DONE pulse.
module mesh_feeder #(
   parameter int N = 3,
   parameter int W = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           WR,
   input  logic           SEL,
   input  logic [3:0]     ADDR,
   input  logic [W-1:0]   DATA,
   input  logic           START,
   output logic [N*W-1:0] A_OUT,
   output logic [N*W-1:0] B_OUT,
   output logic           EN,
   output logic           CLR,
   output logic           BUSY,
   output logic           DONE
);

   localparam int         AW     = (N > 2) ? 2 : 1;
   localparam logic [3:0] T_LAST = 4'(3*N-3);
   localparam logic [2:0] N_L    = 3'(N);

   typedef enum logic [1:0] {IDLE, CLEAR, FEED, FIN} state_t;

   state_t         state, state_n;
   logic [3:0]     t, t_n;
   logic [W-1:0]   a_mem [N][N];
   logic [W-1:0]   b_mem [N][N];
   logic [1:0]     wr_row, wr_col;
   logic           wr_ok;
   logic [N*W-1:0] a_n, b_n;
   int             ka, kb;

   assign wr_row = ADDR[3:2];
   assign wr_col = ADDR[1:0];
   assign wr_ok  = WR && (state == IDLE) && ({1'b0, wr_row} < N_L) && ({1'b0, wr_col} < N_L);

   // Operand storage: written only while idle, cleared by reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_mem[r][c] <= '0;
               b_mem[r][c] <= '0;
            end
         end
      end else if (wr_ok) begin
         if (SEL)
            b_mem[wr_row[AW-1:0]][wr_col[AW-1:0]] <= DATA;
         else
            a_mem[wr_row[AW-1:0]][wr_col[AW-1:0]] <= DATA;
      end
   end

   // State and step counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         t     <= '0;
      end else begin
         state <= state_n;
         t     <= t_n;
      end
   end

   // Next state and next step; the step only advances during FEED.
   always_comb begin
      state_n = state;
      t_n     = t;
      case (state)
         IDLE: begin
            t_n = '0;
            if (START) state_n = CLEAR;
         end
         CLEAR: begin
            t_n     = '0;
            state_n = FEED;
         end
         FEED: begin
            if (t == T_LAST) begin
               state_n = FIN;
               t_n     = '0;
            end else begin
               t_n = t + 4'd1;
            end
         end
         FIN: begin
            t_n     = '0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            t_n     = '0;
         end
      endcase
   end

   // Skewed edge operands for the upcoming step: row i of A and column j of B
   // are delayed by i (resp. j) steps; anything outside the matrix is zero.
   always_comb begin
      a_n = '0;
      b_n = '0;
      ka  = 0;
      kb  = 0;
      if (state_n == FEED) begin
         for (int i = 0; i < N; i++) begin
            ka = int'(t_n) - i;
            if (ka >= 0 && ka < N)
               a_n[i*W +: W] = a_mem[i][ka[AW-1:0]];
         end
         for (int j = 0; j < N; j++) begin
            kb = int'(t_n) - j;
            if (kb >= 0 && kb < N)
               b_n[j*W +: W] = b_mem[kb[AW-1:0]][j];
         end
      end
   end

   // Output registers, loaded from the next-state decode so every output is
   // a flop and aligns with the state it describes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         A_OUT <= '0;
         B_OUT <= '0;
         EN    <= 1'b0;
         CLR   <= 1'b0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         A_OUT <= a_n;
         B_OUT <= b_n;
         EN    <= (state_n == FEED);
         CLR   <= (state_n == CLEAR);
         BUSY  <= (state_n == CLEAR) || (state_n == FEED);
         DONE  <= (state_n == FIN);
      end
   end

endmodule
